// File: rtl/mirror_spi_frame_rx_if.sv
// SPI pins, frame-buffer read port and status pulses of the mirror frame receiver.
// The master side drives SPI and read addresses; the slave side is the receiver.
interface mirror_spi_frame_rx_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned COLS   = 40,
    parameter int unsigned ROWS   = 15
);
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // SPI lines are raw asynchronous pins. Read port: rd_data follows
    // (rd_col, rd_row) one master_clk later, with no valid/ready handshake.
    logic              s_clk;
    logic              ss;
    logic              datain;
    logic [CW-1:0]     rd_col;
    logic [RW-1:0]     rd_row;
    logic [WORD_W-1:0] rd_data;
    logic              word_strobe;
    logic              word_err;
    logic              frame_done;
    logic              frame_error;
    logic              frame_valid;
    logic              buf_sel;

    modport master (
        output s_clk, ss, datain, rd_col, rd_row,
        input  rd_data, word_strobe, word_err, frame_done, frame_error, frame_valid, buf_sel
    );

    modport slave (
        input  s_clk, ss, datain, rd_col, rd_row,
        output rd_data, word_strobe, word_err, frame_done, frame_error, frame_valid, buf_sel
    );
endinterface

// File: rtl/mirror_spi_frame_rx.sv
// SPI slave that assembles words into a ping-pong COLS x ROWS frame buffer.
// The display side reads the front buffer through a registered port.
module mirror_spi_frame_rx #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned COLS      = 40,
    parameter int unsigned ROWS      = 15,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          SS_RESYNC = 1'b1
) (
    input logic                  master_clk,
    input logic                  reset_n,
    mirror_spi_frame_rx_if.slave bus
);
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = $clog2(2 * DEPTH);
    localparam bit          SAMPLE_RISE = (CPOL == CPHA);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    function automatic logic [AW-1:0] cell_addr(input logic bank, input logic [CW-1:0] c,
                                                 input logic [RW-1:0] r);
        return AW'(bank ? DEPTH : 0) + AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    // Synchronisers; the idle reset levels keep the first cycles after reset edge-free.
    logic [2:0] sclk_s;
    logic [2:0] ss_s;
    logic [1:0] din_s;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s <= {3{CPOL}};
            ss_s   <= 3'b111;
            din_s  <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], bus.s_clk};
            ss_s   <= {ss_s[1:0], bus.ss};
            din_s  <= {din_s[0], bus.datain};
        end
    end

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shift_next;
    logic [BW-1:0]     bit_cnt;
    logic              samp_edge;
    logic              ss_rise;
    logic              shift_en;
    logic              word_done;

    // Shifting is gated by the older ss stage so a word finishing in the
    // deassert cycle still completes.
    always_comb begin
        samp_edge  = SAMPLE_RISE ? (sclk_s[1] & ~sclk_s[2]) : (~sclk_s[1] & sclk_s[2]);
        ss_rise    = ss_s[1] & ~ss_s[2];
        shift_en   = samp_edge & ~ss_s[2];
        shift_next = LSB_FIRST ? {din_s[1], shreg[WORD_W-1:1]} : {shreg[WORD_W-2:0], din_s[1]};
        word_done  = shift_en && (bit_cnt == BIT_LAST);
    end

    logic [WORD_W-1:0] word_q;
    logic              wr_pend;
    logic              ss_rise_d;
    logic              word_strobe_q;
    logic              word_err_q;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            word_q        <= '0;
            wr_pend       <= 1'b0;
            ss_rise_d     <= 1'b0;
            word_strobe_q <= 1'b0;
            word_err_q    <= 1'b0;
        end else begin
            wr_pend       <= word_done;
            word_strobe_q <= word_done;
            word_err_q    <= ss_rise && !word_done && (bit_cnt != '0);
            ss_rise_d     <= ss_rise;
            if (word_done) begin
                word_q  <= shift_next;
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (ss_s[1]) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= shift_next;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic          commit;
    logic          abort;
    logic          buf_sel_q;
    logic          frame_valid_q;
    logic          frame_done_q;
    logic          frame_error_q;

    // ss_rise_d lines up with the write of a word that completed in the
    // deassert cycle, so that write is accounted before the abort decision.
    always_comb begin
        col_n  = col;
        row_n  = row;
        commit = 1'b0;
        if (wr_pend) begin
            if (col == COL_LAST && row == ROW_LAST) begin
                col_n  = '0;
                row_n  = '0;
                commit = 1'b1;
            end else if (col == COL_LAST) begin
                col_n = '0;
                row_n = row + 1'b1;
            end else begin
                col_n = col + 1'b1;
            end
        end
        abort = SS_RESYNC && ss_rise_d && ((col_n != '0) || (row_n != '0));
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            col           <= '0;
            row           <= '0;
            buf_sel_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            col           <= abort ? '0 : col_n;
            row           <= abort ? '0 : row_n;
            frame_done_q  <= commit;
            frame_error_q <= abort;
            if (commit) begin
                buf_sel_q     <= ~buf_sel_q;
                frame_valid_q <= 1'b1;
            end
        end
    end

    // buf_sel names the front bank; the SPI side always fills the other one.
    logic [WORD_W-1:0] mem [0:2*DEPTH-1];
    logic [WORD_W-1:0] rd_q;
    logic              rd_in_range;

    always_ff @(posedge master_clk) begin
        if (wr_pend) mem[cell_addr(~buf_sel_q, col, row)] <= word_q;
    end

    assign rd_in_range = (32'(bus.rd_col) < COLS) && (32'(bus.rd_row) < ROWS);

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (frame_valid_q && rd_in_range) begin
            rd_q <= mem[cell_addr(buf_sel_q, bus.rd_col, bus.rd_row)];
        end else begin
            rd_q <= '0;
        end
    end

    assign bus.rd_data     = rd_q;
    assign bus.word_strobe = word_strobe_q;
    assign bus.word_err    = word_err_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_error = frame_error_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.buf_sel     = buf_sel_q;
endmodule
